div_share_ctrl: RTL and testbench

- Shares one pipelined N-stage `div` datapath between M requesters. Each requester has a valid/ready issue channel.
- Round-robin arbitration selects at most one operation per cycle. A tag delay line tracks requester ID and flags alongside the datapath, and results are routed back to the issuing requester.
- Sits between core-side divide users and the free-running, non-stallable `div` pipeline.

---
 rtl/div_share_pkg.sv | 30 +++
 rtl/div.sv | 67 ++++++
 rtl/div_share_ctrl_arb.sv | 61 ++++++
 rtl/div_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_div_share_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_share_pkg.sv
// Shared widths, defaults and helpers for the shared divider controller.
package div_share_pkg;

    localparam int N_DEF       = 8;
    localparam int M_DEF       = 4;
    localparam int DIV_LAT_DEF = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Requester ID width; a single requester still carries a 1-bit ID.
    function automatic int id_width(input int m);
        return (m > 1) ? clog2(m) : 1;
    endfunction

    // Tag field widths for a given configuration: {valid, id, dz, dividend}.
    function automatic int tag_width(input int m, input int n);
        return 1 + id_width(m) + 1 + n;
    endfunction

endpackage

// File: rtl/div.sv
// Free-running N-stage restoring divider. One quotient bit per stage, no
// stall, no reset: whatever sits in the pipe is qualified by the caller.
module div #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic [N-1:0] in_dividend,
    input  logic [N-1:0] in_divisor,
    output logic [N-1:0] out_quotient,
    output logic [N-1:0] out_remainder
);

    logic [N-1:0] rem_q [N];
    logic [N-1:0] rem_d [N];
    logic [N-1:0] quo_q [N];
    logic [N-1:0] quo_d [N];
    logic [N-1:0] dvd_q [N];
    logic [N-1:0] dvd_d [N];
    logic [N-1:0] dvs_q [N];
    logic [N-1:0] dvs_d [N];

    // Each stage shifts the next dividend bit into the partial remainder and
    // subtracts the divisor when it fits.
    always_comb begin
        for (int k = 0; k < N; k++) begin : g_stage
            logic [N-1:0] rin;
            logic [N-1:0] qin;
            logic [N-1:0] din;
            logic [N-1:0] sin;
            logic [N:0]   trial;
            rin   = '0;
            qin   = '0;
            din   = in_dividend;
            sin   = in_divisor;
            if (k > 0) begin
                rin = rem_q[k-1];
                qin = quo_q[k-1];
                din = dvd_q[k-1];
                sin = dvs_q[k-1];
            end
            trial = {rin, din[N-1]};
            if (trial >= {1'b0, sin}) begin
                rem_d[k] = N'(trial - {1'b0, sin});
                quo_d[k] = (qin << 1) | N'(1);
            end else begin
                rem_d[k] = trial[N-1:0];
                quo_d[k] = qin << 1;
            end
            dvd_d[k] = din << 1;
            dvs_d[k] = sin;
        end
    end

    // Pipeline registers; intentionally unreset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            rem_q[k] <= rem_d[k];
            quo_q[k] <= quo_d[k];
            dvd_q[k] <= dvd_d[k];
            dvs_q[k] <= dvs_d[k];
        end
    end

    assign out_quotient  = quo_q[N-1];
    assign out_remainder = rem_q[N-1];

endmodule

// File: rtl/div_share_ctrl_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module div_rr_arb
    import div_share_pkg::*;
#(
    parameter  int M    = 4,
    localparam int ID_W = id_width(M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [M-1:0]    req,
    output logic [M-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any_gnt
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    // Rotating priority search; nothing is granted while reset is held.
    always_comb begin
        int idx;
        int nxt;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        ptr_d   = ptr_q;
        idx     = 0;
        nxt     = 0;
        for (int i = 0; i < M; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= M) begin
                idx = idx - M;
            end
            if (!any_gnt && !rst && req[idx]) begin
                any_gnt = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        for (int i = 0; i < M; i++) begin
            gnt[i] = any_gnt && (int'(gnt_idx) == i);
        end
        if (any_gnt) begin
            nxt = int'(gnt_idx) + 1;
            if (nxt >= M) begin
                nxt = 0;
            end
            ptr_d = ID_W'(nxt);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one pipelined divider among M requesters. A tag line running
// beside the divider carries who issued each op and whether it was a
// divide-by-zero; the tag at the tail qualifies and routes the result.
// DIV_LAT must match the divider depth, which is N for this divider.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter  int N       = N_DEF,
    parameter  int M       = M_DEF,
    parameter  int DIV_LAT = DIV_LAT_DEF,
    localparam int ID_W    = id_width(M),
    localparam int IF_W    = clog2(DIV_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [M-1:0]    req_valid,
    output logic [M-1:0]    req_ready,
    input  logic [M*N-1:0]  req_dividend,
    input  logic [M*N-1:0]  req_divisor,
    output logic [M-1:0]    rsp_valid,
    output logic [N-1:0]    rsp_quotient,
    output logic [N-1:0]    rsp_remainder,
    output logic            rsp_div_by_zero,
    output logic [IF_W-1:0] in_flight
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            dz;
        logic [N-1:0]    dividend;
    } tag_t;

    logic [M-1:0]    gnt;
    logic [ID_W-1:0] gnt_idx;
    logic            any_gnt;

    logic [N-1:0]    op_dividend;
    logic [N-1:0]    op_divisor;
    logic [N-1:0]    div_quo;
    logic [N-1:0]    div_rem;

    tag_t            tag_q [DIV_LAT];
    tag_t            tag_d [DIV_LAT];
    tag_t            tail;

    logic [M-1:0]    rsp_valid_q;
    logic [M-1:0]    rsp_valid_d;
    logic [N-1:0]    rsp_quotient_q;
    logic [N-1:0]    rsp_quotient_d;
    logic [N-1:0]    rsp_remainder_q;
    logic [N-1:0]    rsp_remainder_d;
    logic            rsp_dz_q;
    logic            rsp_dz_d;
    logic [IF_W-1:0] in_flight_q;
    logic [IF_W-1:0] in_flight_d;

    div_rr_arb #(
        .M (M)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign req_ready = gnt;

    // Operand mux; an idle cycle feeds 0/1 so the divider never holds X.
    always_comb begin
        op_dividend = '0;
        op_divisor  = N'(1);
        if (any_gnt) begin
            op_dividend = req_dividend[int'(gnt_idx)*N +: N];
            op_divisor  = req_divisor[int'(gnt_idx)*N +: N];
        end
    end

    div #(
        .N (N)
    ) u_div (
        .clk           (clk),
        .in_dividend   (op_dividend),
        .in_divisor    (op_divisor),
        .out_quotient  (div_quo),
        .out_remainder (div_rem)
    );

    assign tail = tag_q[DIV_LAT-1];

    // Tag line shifts every cycle in lockstep with the divider.
    always_comb begin
        tag_d[0].valid    = any_gnt;
        tag_d[0].id       = gnt_idx;
        tag_d[0].dz       = any_gnt && (op_divisor == '0);
        tag_d[0].dividend = op_dividend;
        for (int k = 1; k < DIV_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Response formation at the tail; data fields hold when nothing retires.
    always_comb begin
        rsp_valid_d     = '0;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_dz_d        = rsp_dz_q;
        if (tail.valid) begin
            for (int i = 0; i < M; i++) begin
                rsp_valid_d[i] = (int'(tail.id) == i);
            end
            if (tail.dz) begin
                rsp_quotient_d  = '1;
                rsp_remainder_d = tail.dividend;
                rsp_dz_d        = 1'b1;
            end else begin
                rsp_quotient_d  = div_quo;
                rsp_remainder_d = div_rem;
                rsp_dz_d        = 1'b0;
            end
        end
    end

    // Occupancy: one in per grant, one out per retiring tag.
    always_comb begin
        in_flight_d = in_flight_q + IF_W'(any_gnt) - IF_W'(tail.valid);
    end

    // State registers; clearing the tags discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DIV_LAT; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q     <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dz_q        <= 1'b0;
            in_flight_q     <= '0;
        end else begin
            for (int k = 0; k < DIV_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            rsp_valid_q     <= rsp_valid_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_dz_q        <= rsp_dz_d;
            in_flight_q     <= in_flight_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_quotient    = rsp_quotient_q;
    assign rsp_remainder   = rsp_remainder_q;
    assign rsp_div_by_zero = rsp_dz_q;
    assign in_flight       = in_flight_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: stimulus pushes hand-computed
// expected responses, a monitor pops and compares whenever rsp_valid fires.
module tb_div_share_ctrl;

    localparam int N       = 8;
    localparam int M       = 4;
    localparam int DIV_LAT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [M-1:0]   req_valid;
    logic [M-1:0]   req_ready;
    logic [M*N-1:0] req_dividend;
    logic [M*N-1:0] req_divisor;
    logic [M-1:0]   rsp_valid;
    logic [N-1:0]   rsp_quotient;
    logic [N-1:0]   rsp_remainder;
    logic           rsp_div_by_zero;
    logic [3:0]     in_flight;

    div_share_ctrl #(.N(N), .M(M), .DIV_LAT(DIV_LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .rsp_valid       (rsp_valid),
        .rsp_quotient    (rsp_quotient),
        .rsp_remainder   (rsp_remainder),
        .rsp_div_by_zero (rsp_div_by_zero),
        .in_flight       (in_flight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         due;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_ops(input int id, input logic [7:0] dvd, input logic [7:0] dvs);
        req_dividend[id*N +: N] = dvd;
        req_divisor[id*N +: N]  = dvs;
    endtask

    task automatic push_exp(input int id, input logic [7:0] q, input logic [7:0] r, input logic dz);
        exp_t e;
        e.id  = id;
        e.q   = q;
        e.r   = r;
        e.dz  = dz;
        e.due = cyc + DIV_LAT + 1;
        exp_q.push_back(e);
    endtask

    // Single-requester issue from a negedge; returns one negedge later.
    task automatic issue(input int id, input logic [7:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] q, input logic [7:0] r, input logic dz);
        set_ops(id, dvd, dvs);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        #1;
        chk("req_ready_single", req_ready, 32'(1 << id));
        push_exp(id, q, r, dz);
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", rsp_valid, 32'(1 << e.id));
                    chk("rsp_quotient", rsp_quotient, e.q);
                    chk("rsp_remainder", rsp_remainder, e.r);
                    chk("rsp_div_by_zero", rsp_div_by_zero, e.dz);
                    chk("rsp_latency", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        chk("ready_in_reset", req_ready, 0);
        req_valid = '0;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_quotient", rsp_quotient, 0);
        chk("reset_remainder", rsp_remainder, 0);
        chk("reset_dz", rsp_div_by_zero, 0);
        chk("reset_in_flight", in_flight, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All four requesters valid for 8 cycles: 0,1,2,3,0,1,2,3.
        set_ops(0, 8'd200, 8'd3);
        set_ops(1, 8'd99,  8'd10);
        set_ops(2, 8'd17,  8'd17);
        set_ops(3, 8'd250, 8'd16);
        begin
            logic [7:0] q_tab [4];
            logic [7:0] r_tab [4];
            q_tab = '{8'd66, 8'd9, 8'd1, 8'd15};
            r_tab = '{8'd2,  8'd9, 8'd0, 8'd10};
            for (int k = 0; k < 8; k++) begin
                req_valid = '1;
                #1;
                chk("rr_grant", req_ready, 32'(1 << (k % 4)));
                push_exp(k % 4, q_tab[k % 4], r_tab[k % 4], 1'b0);
                @(negedge clk);
            end
        end
        req_valid = '0;
        chk("in_flight_full", in_flight, 8);
        wait_drain();
        chk("in_flight_drained", in_flight, 0);

        // Single op: 100/7 from requester 0.
        issue(0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        for (int k = 0; k < DIV_LAT; k++) begin
            chk("in_flight_single", in_flight, 1);
            @(negedge clk);
        end
        chk("in_flight_retired", in_flight, 0);
        chk("rsp_single_valid", rsp_valid, 4'b0001);
        @(negedge clk);
        chk("rsp_valid_pulse", rsp_valid, 0);
        chk("rsp_quotient_hold", rsp_quotient, 14);
        chk("rsp_remainder_hold", rsp_remainder, 2);

        // Divide by zero from requester 2 (pointer moves to 3).
        issue(2, 8'd37, 8'd0, 8'd255, 8'd37, 1'b1);
        wait_drain();

        // Wrap: pointer at 3 with requesters 2 and 3 valid.
        set_ops(2, 8'd60, 8'd7);
        set_ops(3, 8'd81, 8'd9);
        req_valid = 4'b1100;
        #1;
        chk("wrap_first", req_ready, 4'b1000);
        push_exp(3, 8'd9, 8'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("wrap_second", req_ready, 4'b0100);
        push_exp(2, 8'd8, 8'd4, 1'b0);
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("wrap_ptr_is_3", req_ready, 4'b1000);
        push_exp(3, 8'd9, 8'd0, 1'b0);
        @(negedge clk);
        req_valid = '0;
        wait_drain();

        // Boundary operands, issued back to back.
        issue(1, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        issue(2, 8'd5,   8'd9, 8'd0,   8'd5, 1'b0);
        issue(3, 8'd0,   8'd3, 8'd0,   8'd0, 1'b0);
        issue(0, 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        wait_drain();

        // Reset mid-flight: three ops discarded, nothing may come back.
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'(1 << k);
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        #1;
        chk("ready_in_midreset", req_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            chk("rsp_after_reset", rsp_valid, 0);
            chk("in_flight_after_reset", in_flight, 0);
            @(negedge clk);
        end

        // Pointer back at 0: all valid must grant requester 0.
        set_ops(0, 8'd123, 8'd10);
        req_valid = '1;
        #1;
        chk("ptr_reset_grant", req_ready, 4'b0001);
        push_exp(0, 8'd12, 8'd3, 1'b0);
        @(negedge clk);
        req_valid = '0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
